alu_iter: RTL and testbench

Iterative execute-stage ALU that sits directly downstream of the ALU control unit. It consumes the 4-bit ALU operation code and two XLEN-bit operands, and returns a registered result plus a zero flag through a valid/ready handshake. Logic, arithmetic and compare operations complete in one cycle. Shifts use a 1-bit-per-cycle serial shifter, which saves the area of a barrel shifter.

---
 rtl/alu_iter.sv | 166 ++++++++++++++++
 tb/tb_alu_iter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// Execute-stage ALU with a valid/ready handshake. Logic, arithmetic and compare
// ops finish in one cycle; shifts go through a 1-bit-per-cycle serial shifter.
module alu_iter #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [3:0]      i_alu_control,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   output logic            o_valid,
   output logic [XLEN-1:0] o_result,
   output logic            o_zero
);

   // state   | meaning
   // S_IDLE  | ready for a request; single-cycle ops complete from here
   // S_SHIFT | serial shift in progress, one bit per cycle, cnt_q bits left
   typedef enum logic {S_IDLE, S_SHIFT} state_t;
   typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA} sh_type_t;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_SLL  = 4'b0010;
   localparam logic [3:0] OP_SLT  = 4'b0011;
   localparam logic [3:0] OP_SLTU = 4'b0100;
   localparam logic [3:0] OP_XOR  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_OR   = 4'b1000;
   localparam logic [3:0] OP_AND  = 4'b1001;
   localparam logic [3:0] OP_LUI  = 4'b1010;

   state_t          state_q, state_d;
   sh_type_t        sh_type_q, sh_type_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;
   logic            valid_q, valid_d;

   logic            accept;
   logic            is_shift;
   logic [4:0]      shamt;
   sh_type_t        req_sh_type;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] acc_step;

   assign shamt  = i_op_b[4:0];
   assign accept = i_valid && (state_q == S_IDLE);

   always_comb begin
      is_shift    = 1'b0;
      req_sh_type = SH_SLL;
      case (i_alu_control)
         OP_SLL: begin is_shift = 1'b1; req_sh_type = SH_SLL; end
         OP_SRL: begin is_shift = 1'b1; req_sh_type = SH_SRL; end
         OP_SRA: begin is_shift = 1'b1; req_sh_type = SH_SRA; end
         default: ;
      endcase
   end

   // Shift ops only reach this path with shamt=0, where the result is op_a.
   always_comb begin
      alu_res = '0;
      case (i_alu_control)
         OP_ADD:  alu_res = i_op_a + i_op_b;
         OP_SUB:  alu_res = i_op_a - i_op_b;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (i_op_a < i_op_b)};
         OP_XOR:  alu_res = i_op_a ^ i_op_b;
         OP_OR:   alu_res = i_op_a | i_op_b;
         OP_AND:  alu_res = i_op_a & i_op_b;
         OP_LUI:  alu_res = i_op_b;
         OP_SLL, OP_SRL, OP_SRA: alu_res = i_op_a;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      acc_step = acc_q;
      case (sh_type_q)
         SH_SLL:  acc_step = {acc_q[XLEN-2:0], 1'b0};
         SH_SRL:  acc_step = {1'b0, acc_q[XLEN-1:1]};
         SH_SRA:  acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
         default: acc_step = acc_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept && is_shift && (shamt != 5'd0)) state_d = S_SHIFT;
         S_SHIFT: if (cnt_q == 5'd1) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state_q == S_IDLE);
   end

   always_comb begin
      sh_type_d = sh_type_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      result_d  = result_q;
      zero_d    = zero_q;
      valid_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_shift && (shamt != 5'd0)) begin
                  acc_d     = i_op_a;
                  cnt_d     = shamt;
                  sh_type_d = req_sh_type;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  valid_d  = 1'b1;
               end
            end
         end
         S_SHIFT: begin
            acc_d = acc_step;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               result_d = acc_step;
               zero_d   = (acc_step == '0);
               valid_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sh_type_q <= SH_SLL;
         cnt_q     <= '0;
         acc_q     <= '0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         valid_q   <= 1'b0;
      end else begin
         sh_type_q <= sh_type_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         valid_q   <= valid_d;
      end
   end

   assign o_valid  = valid_q;
   assign o_result = result_q;
   assign o_zero   = zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: hand-computed vectors covering single-cycle ops,
// serial shifts, request holding during a shift and reset abort.
module tb_alu_iter;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [3:0]  i_alu_control;
   logic [31:0] i_op_a;
   logic [31:0] i_op_b;
   logic        o_valid;
   logic [31:0] o_result;
   logic        o_zero;

   int n_checks = 0;
   int n_fail   = 0;

   alu_iter #(.XLEN(32)) u_dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_valid       (i_valid),
      .o_ready       (o_ready),
      .i_alu_control (i_alu_control),
      .i_op_a        (i_op_a),
      .i_op_b        (i_op_b),
      .o_valid       (o_valid),
      .o_result      (o_result),
      .o_zero        (o_zero)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic present(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      i_valid       = 1'b1;
      i_alu_control = op;
      i_op_a        = a;
      i_op_b        = b;
   endtask

   task automatic idle();
      i_valid = 1'b0;
   endtask

   // Single-cycle op: accepted at the next edge, completion visible right after.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      present(op, a, b);
      step();
      check({tag, ".valid"}, {31'b0, o_valid}, 32'd1);
      check({tag, ".result"}, o_result, exp);
      check({tag, ".zero"}, {31'b0, o_zero}, {31'b0, (exp == 32'd0)});
      check({tag, ".ready"}, {31'b0, o_ready}, 32'd1);
   endtask

   task automatic run_shift(input string tag, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int shamt, input logic [31:0] exp);
      present(op, a, b);
      step();
      idle();
      for (int i = 0; i < shamt; i++) begin
         check({tag, ".busy_ready"}, {31'b0, o_ready}, 32'd0);
         check({tag, ".busy_valid"}, {31'b0, o_valid}, 32'd0);
         step();
      end
      check({tag, ".valid"}, {31'b0, o_valid}, 32'd1);
      check({tag, ".result"}, o_result, exp);
      check({tag, ".zero"}, {31'b0, o_zero}, {31'b0, (exp == 32'd0)});
      check({tag, ".ready"}, {31'b0, o_ready}, 32'd1);
      step();
      check({tag, ".pulse"}, {31'b0, o_valid}, 32'd0);
   endtask

   initial begin
      i_rst_n       = 1'b0;
      i_valid       = 1'b0;
      i_alu_control = 4'h0;
      i_op_a        = 32'h0;
      i_op_b        = 32'h0;
      step();
      step();
      i_rst_n = 1'b1;
      check("rst.result", o_result, 32'h0);
      check("rst.zero", {31'b0, o_zero}, 32'd1);
      check("rst.ready", {31'b0, o_ready}, 32'd1);
      check("rst.valid", {31'b0, o_valid}, 32'd0);
      step();

      run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      idle();
      step();
      check("add_wrap.pulse", {31'b0, o_valid}, 32'd0);
      check("add_wrap.hold", o_result, 32'h0000_0000);

      run_op("sub", 4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE);
      run_op("slt", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'h0000_0001);
      run_op("sltu", 4'b0100, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
      run_op("xor", 4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
      run_op("or", 4'b1000, 32'h0000_FFFF, 32'h00FF_0000, 32'h00FF_FFFF);
      run_op("and", 4'b1001, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h000F_000F);
      run_op("lui", 4'b1010, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000);
      run_op("op_1111", 4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000);
      run_op("sll_sh0", 4'b0010, 32'h0000_1234, 32'h0000_0020, 32'h0000_1234);
      idle();
      step();

      run_shift("sra4", 4'b0111, 32'h8000_0000, 32'd4, 4, 32'hF800_0000);
      run_shift("srl4", 4'b0110, 32'h8000_0000, 32'd4, 4, 32'h0800_0000);
      run_shift("sll31", 4'b0010, 32'h0000_0001, 32'd31, 31, 32'h8000_0000);
      run_shift("srl_out", 4'b0110, 32'h0000_0001, 32'd1, 1, 32'h0000_0000);

      // Request held during a shift is ignored until the shift completes.
      present(4'b0010, 32'd1, 32'd10);
      step();
      present(4'b0000, 32'd2, 32'd3);
      for (int i = 0; i < 10; i++) begin
         check("hold.busy_ready", {31'b0, o_ready}, 32'd0);
         check("hold.busy_valid", {31'b0, o_valid}, 32'd0);
         step();
      end
      check("hold.sll_valid", {31'b0, o_valid}, 32'd1);
      check("hold.sll_result", o_result, 32'h0000_0400);
      check("hold.ready", {31'b0, o_ready}, 32'd1);
      step();
      idle();
      check("hold.add_valid", {31'b0, o_valid}, 32'd1);
      check("hold.add_result", o_result, 32'd5);
      check("hold.add_zero", {31'b0, o_zero}, 32'd0);
      step();
      check("hold.add_pulse", {31'b0, o_valid}, 32'd0);

      // Reset in the middle of a 20-bit shift aborts it.
      present(4'b0010, 32'd1, 32'd20);
      step();
      idle();
      step();
      step();
      check("abort.busy", {31'b0, o_ready}, 32'd0);
      i_rst_n = 1'b0;
      step();
      i_rst_n = 1'b1;
      check("abort.ready", {31'b0, o_ready}, 32'd1);
      check("abort.result", o_result, 32'h0);
      check("abort.zero", {31'b0, o_zero}, 32'd1);
      for (int i = 0; i < 25; i++) begin
         check("abort.no_valid", {31'b0, o_valid}, 32'd0);
         step();
      end
      check("abort.result_end", o_result, 32'h0);

      run_op("post_abort_add", 4'b0000, 32'd40, 32'd2, 32'd42);
      idle();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
